// File: rtl/l1_mem_bridge.sv
// Write-through store buffer and miss-fill bridge between the L1 D-cache and main memory.
// Fills hit the buffer in 1 cycle, else one memory read; stores stall on a full buffer, fills while one is outstanding.
module l1_mem_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WB_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wb_empty,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(WB_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fifo_addr [WB_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WB_DEPTH];
  logic [WB_DEPTH-1:0]   fifo_vld;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         wptr;
  logic [PW:0]           count;
  logic [PW:0]           count_nxt;
  logic                  rd_pending;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  push;
  logic                  pop;
  logic                  rd_acc;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PW-1:0]         idx;
  logic                  stay_wr;

  assign wr_ready = !rst && (count != FULL_CNT);
  // Holding off a new fill while its predecessor's data is on the bus keeps rd_valid a true one-cycle pulse.
  assign rd_ready = !rst && !rd_pending && !rd_valid;

  assign push   = wr_req && wr_ready;
  assign rd_acc = rd_req && rd_ready;
  assign pop    = (state == WR_BUSY) && mem_req && mem_ack;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  assign stay_wr = ((state == IDLE) && !rd_pending && (count != '0)) ||
                   ((state == WR_BUSY) && !pop);

  // Walk entries oldest to youngest so the last match wins; a same-cycle store is younger still.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = rptr;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (fifo_vld[idx] && (fifo_addr[idx] == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[idx];
      end
    end
    if (push && (wr_addr == rd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= wr_addr;
      fifo_data[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      fifo_vld   <= '0;
      rd_pending <= 1'b0;
      pend_addr  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      wb_empty   <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
      count    <= count_nxt;
      wb_empty <= (count_nxt == '0) && !stay_wr;

      if (pop) begin
        fifo_vld[rptr] <= 1'b0;
        rptr           <= rptr + 1'b1;
      end
      if (push) begin
        fifo_vld[wptr] <= 1'b1;
        wptr           <= wptr + 1'b1;
      end

      if (rd_acc) begin
        if (fwd_hit) begin
          rd_valid <= 1'b1;
          rd_data  <= fwd_data;
        end else begin
          rd_pending <= 1'b1;
          pend_addr  <= rd_addr;
        end
      end

      case (state)
        IDLE: begin
          // A pending read missed every buffered address, so it may overtake the queued stores.
          if (rd_pending) begin
            state    <= RD_BUSY;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pend_addr;
          end else if (count != '0) begin
            state     <= WR_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= fifo_addr[rptr];
            mem_wdata <= fifo_data[rptr];
          end
        end
        WR_BUSY: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        RD_BUSY: begin
          if (mem_ack) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            rd_data    <= mem_rdata;
            rd_valid   <= 1'b1;
            rd_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
